// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: MAC FSM state type and default widths.
// Also consumed by the quantization stage.
package conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 65;
    localparam int DEF_LEN_W  = 11;
    localparam int BIAS_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } mac_state_t;

endpackage

// File: rtl/conv_mult_reg.sv
// Registered signed DATA_W x DATA_W multiplier; the product register only loads when en is high.
module conv_mult_reg
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= a * b;
        end
    end

endmodule

// File: rtl/conv_mac_accum.sv
// Dot-product MAC for one convolution output: bias + sum(act*wgt), one term per cycle.
// Build option CONV_MAC_RELU_EN clamps negative results to zero when the result is latched.
module conv_mac_accum
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] act,
    input  logic signed [DATA_W-1:0] wgt,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    mac_state_t state, state_nxt;

    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic                      prod_vld;
    logic                      hs;
    logic                      last_hs;

    function automatic logic signed [ACC_W-1:0] shape(input logic signed [ACC_W-1:0] v);
`ifdef CONV_MAC_RELU_EN
        return v[ACC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign hs       = in_valid && in_ready;
    assign last_hs  = hs && (cnt == len_q - LEN_W'(1));
    assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_sum  = acc + (prod_vld ? prod_ext : '0);

    conv_mult_reg #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk (clk),
        .rst (rst),
        .en  (hs),
        .a   (act),
        .b   (wgt),
        .p   (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state defaults to the current state first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (last_hs) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The product stage lags the handshake by one cycle, so DRAIN folds in the final term.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            prod_vld <= 1'b0;
            acc_out  <= '0;
        end else begin
            prod_vld <= hs;
            if (state == IDLE && start) begin
                acc   <= bias_ext;
                cnt   <= '0;
                len_q <= len;
                if (len == '0) begin
                    acc_out <= shape(bias_ext);
                end
            end else begin
                acc <= acc_sum;
                if (hs) begin
                    cnt <= cnt + LEN_W'(1);
                end
                if (state == DRAIN) begin
                    acc_out <= shape(acc_sum);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_accum.sv
// Self-checking bench for conv_mac_accum: directed corner jobs plus randomized jobs against a sum-of-products model.
module tb_conv_mac_accum;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 65;
    localparam int LEN_W  = 11;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic signed [31:0]       bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] act;
    logic signed [DATA_W-1:0] wgt;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;

    conv_mac_accum #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act       (act),
        .wgt       (wgt),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [DATA_W-1:0] qa[$];
    logic signed [DATA_W-1:0] qw[$];

    task automatic check(input string tag, input logic signed [ACC_W-1:0] got,
                         input logic signed [ACC_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias plus the plain sum of the queued products, optionally clamped at zero.
    function automatic logic signed [ACC_W-1:0] golden(input logic signed [31:0] b);
        logic signed [ACC_W-1:0] s;
        s = b;
        foreach (qa[i]) begin
            int p;
            p = qa[i] * qw[i];
            s = s + p;
        end
`ifdef CONV_MAC_RELU_EN
        if (s < 0) s = '0;
`endif
        return s;
    endfunction

    task automatic clear_q();
        qa.delete();
        qw.delete();
    endtask

    task automatic push(input int a, input int w);
        qa.push_back(DATA_W'(a));
        qw.push_back(DATA_W'(w));
    endtask

    // mode 0: back-to-back, 1: in_valid toggles 1,0,1,..., 2: random gaps
    task automatic run_job(input logic signed [31:0] b, input int mode, input int hold,
                           input bit spurious, input string tag);
        int n, idx, budget;
        bit tg, hs;
        logic signed [ACC_W-1:0] exp;
        n   = qa.size();
        exp = golden(b);
        start = 1'b1;
        len   = LEN_W'(n);
        bias  = b;
        tick();
        start = 1'b0;
        len   = '0;
        bias  = '0;
        check({tag, "/busy"}, busy, 1);
        if (n == 0) begin
            check({tag, "/valid_len0"}, out_valid, 1);
            check({tag, "/acc_len0"}, acc_out, exp);
        end else begin
            check({tag, "/ready_accum"}, in_ready, 1);
            idx    = 0;
            budget = 4 * n + 20;
            tg     = 1'b1;
            while (idx < n && budget > 0) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = tg;
                    default: in_valid = ($urandom_range(3) != 0);
                endcase
                tg  = ~tg;
                act = qa[idx];
                wgt = qw[idx];
                if (spurious && idx == n / 2) begin
                    start = 1'b1;
                    len   = LEN_W'(3);
                    bias  = 32'sd12345;
                end
                if (!in_ready) begin
                    check({tag, "/ready_lost"}, in_ready, 1);
                    break;
                end
                hs = in_valid && in_ready;
                tick();
                start = 1'b0;
                if (hs) idx++;
                budget--;
            end
            in_valid = 1'b0;
            if (idx < n) check({tag, "/feed_count"}, idx, n);
            check({tag, "/ready_drain"}, in_ready, 0);
            check({tag, "/valid_drain"}, out_valid, 0);
            tick();
            check({tag, "/valid_t2"}, out_valid, 1);
            check({tag, "/acc_t2"}, acc_out, exp);
        end
        repeat (hold) begin
            tick();
            check({tag, "/valid_hold"}, out_valid, 1);
            check({tag, "/acc_hold"}, acc_out, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, out_valid, 0);
        check({tag, "/idle"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        act       = '0;
        wgt       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset/acc_out", acc_out, 0);
        check("reset/out_valid", out_valid, 0);
        check("reset/in_ready", in_ready, 0);
        check("reset/busy", busy, 0);
        rst = 1'b0;

        clear_q();
        push(2, 3);
        push(-4, 5);
        push(7, -1);
        run_job(32'sd10, 0, 0, 1'b0, "three_terms");

        clear_q();
        run_job(-32'sd998, 0, 2, 1'b0, "len_zero");

        clear_q();
        repeat (4) push(1, 1);
        run_job(32'sd5, 1, 4, 1'b0, "gapped_hold");

        clear_q();
        repeat (1024) push(-128, -128);
        run_job(32'sd0, 0, 0, 1'b0, "max_len");

        clear_q();
        for (int i = 0; i < 8; i++) push($urandom_range(255), $urandom_range(255));
        run_job(-32'sd77, 0, 1, 1'b1, "start_ignored");

        start = 1'b1;
        len   = LEN_W'(4);
        bias  = 32'sd7;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        act      = 8'sd3;
        wgt      = 8'sd3;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("mid_rst/acc_out", acc_out, 0);
        check("mid_rst/out_valid", out_valid, 0);
        check("mid_rst/in_ready", in_ready, 0);
        check("mid_rst/busy", busy, 0);
        rst = 1'b0;
        clear_q();
        run_job(32'sd8179, 0, 0, 1'b0, "after_rst");

        for (int j = 0; j < 10; j++) begin
            clear_q();
            for (int i = 0; i < int'($urandom_range(24)); i++)
                push($urandom_range(255), $urandom_range(255));
            run_job($urandom(), $urandom_range(2), $urandom_range(3), 1'($urandom_range(1)),
                    $sformatf("rand%0d", j));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_mac_accum.md
CONV_MAC_ACCUM -- requirements
Module: conv_mac_accum

Interface
REQ-001 Parameter DATA_W, default 8: signed activation and weight width.
REQ-002 Parameter ACC_W, default 65: signed accumulator/result width; matches the quantization stage input.
REQ-003 Parameter LEN_W, default 11: width of the term-count port; maximum length is 2^LEN_W-1.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  begin one dot product; sampled only in IDLE.
REQ-008 len  in  LEN_W  number of product terms; sampled with start.
REQ-009 bias  in  32  signed bias; sampled with start.
REQ-010 in_valid  in  1  act/wgt pair present.
REQ-011 in_ready  out  1  block accepts a pair.
REQ-012 act  in  DATA_W  signed activation.
REQ-013 wgt  in  DATA_W  signed weight.
REQ-014 acc_out  out  ACC_W  signed result for the quantization stage.
REQ-015 out_valid  out  1  acc_out holds a result.
REQ-016 out_ready  in  1  downstream accepts the result.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE->ACCUM on start with len!=0.
- IDLE->DONE on start with len==0.
- ACCUM->DRAIN on the len-th handshake.
- DRAIN->DONE after one cycle.
- DONE->IDLE on out_ready.
REQ-019 When start is accepted: acc is loaded with bias sign-extended to ACC_W, the term counter is cleared, and len is latched.
REQ-020 in_ready SHALL be 1 only in ACCUM. A handshake is in_valid&&in_ready.
REQ-021 On each handshake, act*wgt (full 2*DATA_W signed product) is registered in a product stage. On the following cycle, acc += sign-extended product. One term per cycle, no bubbles.
REQ-022 in_valid gaps insert no terms. The counter advances only on handshakes.
REQ-023 Latency: last handshake at cycle t -> out_valid at t+2.
REQ-024 len==0: out_valid rises 1 cycle after start, with acc_out = bias.
REQ-025 In DONE, out_valid=1 and acc_out is stable until the out_valid&&out_ready cycle. out_valid falls the next cycle.
REQ-026 start while busy SHALL be ignored (no effect, not queued).
REQ-027 The accumulator wraps modulo 2^ACC_W. No saturation is required, because the default widths cannot overflow.
REQ-028 The acc_out register is driven directly with no combinational path from inputs. in_ready depends only on state.

Reset
REQ-029 rst SHALL force IDLE, acc=0, counter=0, product stage=0, acc_out=0, out_valid=0, in_ready=0, busy=0.
REQ-030 rst during any state SHALL discard the in-flight computation. The first cycle after rst deasserts accepts start.

Configuration
REQ-031 Macro CONV_MAC_RELU_EN defined: acc_out = (acc<0) ? 0 : acc when entering DONE. Undefined: acc_out = acc unmodified (signed values reach quantization).

Structure
REQ-032 Shared package conv_pkg holds the FSM state typedef (mac_state_t) and the default DATA_W/ACC_W/LEN_W constants, reused by the quantization stage.
REQ-033 One sub-module, conv_mult_reg: a registered signed DATA_W x DATA_W multiplier with enable, instantiated once.

Verification
REQ-034 bias=10, len=3, pairs (2,3),(-4,5),(7,-1) back-to-back:
- acc_out=-11 at t+2;
- with CONV_MAC_RELU_EN, acc_out=0.
REQ-035 bias=0, len=1024, all pairs (-128,-128) -> acc_out=16777216. in_ready is low from the cycle after the 1024th handshake.
REQ-036 len=0, bias=-998 -> out_valid 1 cycle after start, acc_out=-998 (unRELU'd build).
REQ-037 bias=5, len=4, pairs (1,1) with in_valid toggling 1,0,1,0,... and out_ready held low 5 cycles:
- acc_out=9, held stable while waiting;
- out_valid drops one cycle after out_ready.
REQ-038 rst pulsed mid-ACCUM after 2 of 4 terms:
- all outputs are 0 on the next cycle;
- a new start with bias=8179, len=0 yields acc_out=8179.
REQ-039 start pulsed during ACCUM -> ignored. The result equals the single-run golden value.
